// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, sequencer state type and s-box affine constant
package aes_pkg;

   localparam int BYTE_W      = 8;
   localparam int AES_STATE_W = 128;

   // S(0) of the forward s-box; handy as a known-answer value.
   localparam logic [7:0] SBOX_AFFINE_C = 8'h63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/sub_bytes_sequencer.sv
// rtl/sub_bytes_sequencer.sv - streams a state byte by byte through a shared s-box and reassembles it
module sub_bytes_sequencer
   import aes_pkg::*;
#(
   parameter int BYTES = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BYTE_W*BYTES-1:0] in_state,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BYTE_W*BYTES-1:0] out_state,
   output logic                    sbox_in_valid,
   input  logic                    sbox_in_ready,
   output logic [BYTE_W-1:0]       sbox_in_data,
   input  logic                    sbox_out_valid,
   output logic                    sbox_out_ready,
   input  logic [BYTE_W-1:0]       sbox_out_data
);

   localparam int CNT_W = $clog2(BYTES + 1);
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   seq_state_t state_q;
   logic       in_ready_q;

   logic [BYTES-1:0][BYTE_W-1:0] src_q, src_d;
   logic [BYTES-1:0][BYTE_W-1:0] res_q, res_d;
   logic [CNT_W-1:0]             issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]             ret_cnt_q, ret_cnt_d;

   logic issue_pending;
   logic in_fire;
   logic issue_fire;
   logic ret_fire;

   // Handshake qualifiers; the counters saturate at BYTES so they never wrap.
   assign issue_pending = (state_q == RUN) && (issue_cnt_q < CNT_MAX);
   assign in_fire       = in_valid && in_ready_q;
   assign issue_fire    = issue_pending && sbox_in_ready;
   assign ret_fire      = (state_q == RUN) && sbox_out_valid && (ret_cnt_q < CNT_MAX);

   // Every output is decoded from registers only, so no input reaches an output combinationally.
   assign in_ready       = in_ready_q;
   assign out_valid      = (state_q == DONE);
   assign out_state      = res_q;
   assign sbox_in_valid  = issue_pending;
   assign sbox_in_data   = issue_pending ? src_q[issue_cnt_q[IDX_W-1:0]] : '0;
   assign sbox_out_ready = (state_q == RUN);

   // Next-state for source/result registers and the two independent counters.
   always_comb begin
      src_d       = src_q;
      res_d       = res_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      if (in_fire) begin
         src_d       = in_state;
         issue_cnt_d = '0;
         ret_cnt_d   = '0;
      end
      if (issue_fire) begin
         issue_cnt_d = issue_cnt_q + CNT_ONE;
      end
      if (ret_fire) begin
         res_d[ret_cnt_q[IDX_W-1:0]] = sbox_out_data;
         ret_cnt_d                   = ret_cnt_q + CNT_ONE;
      end
   end

   // Datapath registers; reset discards any partial result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         src_q       <= '0;
         res_q       <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         src_q       <= src_d;
         res_q       <= res_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   // Control FSM with registered in_ready, held low through reset and raised on the first edge after it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_fire) begin
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (ret_fire && (ret_cnt_q == CNT_LAST)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// tb/tb_sub_bytes_sequencer.sv - randomized self-checking bench against a GF(2^8) s-box reference
module tb_sub_bytes_sequencer;

   localparam int BYTES = 16;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [127:0]   in_state = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [127:0]   out_state;
   logic           sbox_in_valid;
   logic           sbox_in_ready = 1'b0;
   logic [7:0]     sbox_in_data;
   logic           sbox_out_valid = 1'b0;
   logic           sbox_out_ready;
   logic [7:0]     sbox_out_data = '0;

   sub_bytes_sequencer #(.BYTES(BYTES)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_state       (in_state),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_state      (out_state),
      .sbox_in_valid  (sbox_in_valid),
      .sbox_in_ready  (sbox_in_ready),
      .sbox_in_data   (sbox_in_data),
      .sbox_out_valid (sbox_out_valid),
      .sbox_out_ready (sbox_out_ready),
      .sbox_out_data  (sbox_out_data)
   );

   initial forever #5 clock = ~clock;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         acc_cyc  = 0;
   int         issued   = 0;
   int         max_cnt  = 0;
   bit         stall    = 1'b0;
   bit         spurious = 1'b0;
   logic [7:0] sbox_tbl [256];
   logic [7:0] pend [$];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   // Forward s-box from its definition: multiplicative inverse then affine map.
   task automatic build_tbl();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4)
                       ^ aes_pkg::SBOX_AFFINE_C;
      end
   endtask

   function automatic logic [127:0] sub_state(input logic [127:0] st);
      logic [127:0] r;
      for (int i = 0; i < BYTES; i++) r[8*i +: 8] = sbox_tbl[st[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Latency-1 s-box model: drive at negedge, then record the handshakes the next edge will take.
   initial forever begin
      @(negedge clock);
      sbox_in_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!reset) begin
         sbox_out_valid = 1'b0;
         sbox_out_data  = 8'h00;
      end else if (pend.size() > 0) begin
         sbox_out_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         sbox_out_data  = pend[0];
      end else begin
         sbox_out_valid = spurious;
         sbox_out_data  = spurious ? 8'hAA : 8'h00;
      end
      #1;
      if (int'(dut.issue_cnt_q) > max_cnt) max_cnt = int'(dut.issue_cnt_q);
      if (int'(dut.ret_cnt_q) > max_cnt) max_cnt = int'(dut.ret_cnt_q);
      if (!reset) begin
         pend.delete();
      end else begin
         if (sbox_out_valid && sbox_out_ready) void'(pend.pop_front());
         if (sbox_in_valid && sbox_in_ready) begin
            pend.push_back(sbox_tbl[sbox_in_data]);
            issued++;
         end
      end
   end

   task automatic send(input logic [127:0] st);
      int n = 0;
      issued   = 0;
      in_valid = 1'b1;
      in_state = st;
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      check_eq("accept", in_ready, 1'b1);
      acc_cyc = cyc;
      @(negedge clock);
      in_valid = 1'b0;
      in_state = rand128();
   endtask

   task automatic recv(input string tag, input logic [127:0] exp, input int hold, output int lat);
      int n = 0;
      logic [127:0] snap;
      while (!out_valid && n < 2000) begin
         @(negedge clock);
         n++;
      end
      lat = cyc - acc_cyc;
      check_eq({tag, " out_valid"}, out_valid, 1'b1);
      check_eq({tag, " out_state"}, out_state, exp);
      snap = out_state;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check_eq({tag, " held valid"}, out_valid, 1'b1);
         check_eq({tag, " held state"}, out_state, snap);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check_eq({tag, " released"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " ctrl"}, {in_ready, out_valid, sbox_in_valid, sbox_out_ready}, 4'b0000);
      check_eq({tag, " out_state"}, out_state, 128'h0);
      check_eq({tag, " sbox_in_data"}, sbox_in_data, 8'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      logic [127:0] st;
      logic [127:0] st2;
      logic [127:0] b2b_st  [4];
      logic [127:0] b2b_exp [4];
      int k_in, k_out;
      bit acc, ouths, expect_rdy;

      build_tbl();
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b1;
      @(negedge clock);
      check_eq("in_ready after reset", in_ready, 1'b1);

      // Known-answer vectors with a zero-wait s-box.
      send(128'h0);
      recv("zero", {16{8'h63}}, 0, lat);
      check_eq("zero latency", 128'(lat), 128'd18);

      spurious = 1'b1;
      repeat (3) @(negedge clock);
      spurious = 1'b0;
      send({96'h0, 32'hFF530100});
      recv("bytes", {{12{8'h63}}, 32'h16ED7C63}, 0, lat);
      check_eq("bytes latency", 128'(lat), 128'd18);

      send(128'h193DE3BEA0F4E22B9AC68D2AE9F84808);
      recv("fips", 128'hD42711AEE0BF98F1B8B45DE51E415230, 0, lat);

      // Random stalls on both s-box sides with a slow consumer.
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         st = rand128();
         send(st);
         recv("stall", sub_state(st), 5, lat);
         check_eq("stall issue count", 128'(issued), 128'd16);
      end
      stall = 1'b0;
      check_eq("counter max", 128'(max_cnt <= BYTES), 128'd1);

      // Reset after seven issues, then a clean state must come through untouched.
      st = rand128();
      send(st);
      n = 0;
      while (issued < 7 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check_eq("issues before reset", 128'(issued), 128'd7);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("in_ready after mid reset", in_ready, 1'b1);
      st2 = rand128();
      send(st2);
      recv("post reset", sub_state(st2), 0, lat);
      check_eq("post reset latency", 128'(lat), 128'd18);

      // Back-to-back states with in_valid held high and the consumer always ready.
      for (int k = 0; k < 4; k++) begin
         b2b_st[k]  = rand128();
         b2b_exp[k] = sub_state(b2b_st[k]);
      end
      k_in       = 0;
      k_out      = 0;
      expect_rdy = 1'b0;
      n          = 0;
      in_valid   = 1'b1;
      in_state   = b2b_st[0];
      out_ready  = 1'b1;
      while (k_out < 4 && n < 1000) begin
         if (expect_rdy) check_eq("b2b in_ready return", in_ready, 1'b1);
         acc   = in_valid && in_ready;
         ouths = out_valid && out_ready;
         if (ouths) begin
            check_eq("b2b out_state", out_state, b2b_exp[k_out]);
            check_eq("b2b in_ready during output", in_ready, 1'b0);
            k_out++;
         end
         expect_rdy = ouths;
         @(negedge clock);
         n++;
         if (acc) begin
            k_in++;
            if (k_in < 4) in_state = b2b_st[k_in];
            else in_valid = 1'b0;
         end
      end
      if (expect_rdy) check_eq("b2b in_ready return", in_ready, 1'b1);
      check_eq("b2b states out", 128'(k_out), 128'd4);
      check_eq("b2b states in", 128'(k_in), 128'd4);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
